// File: rtl/fp_op_dispatch_if.sv
// fp_op_dispatch_if: opcode FIFO read port plus
// FP datapath start/done control bundle.
interface fp_op_dispatch_if;
  logic       fifo_empty;
  logic [2:0] opcode_in;
  logic       read;
  logic       fpu_start;
  logic [2:0] fpu_op;
  logic       fpu_done;

  modport master (
    input  fifo_empty,
    input  opcode_in,
    input  fpu_done,
    output read,
    output fpu_start,
    output fpu_op
  );

  modport slave (
    output fifo_empty,
    output opcode_in,
    output fpu_done,
    input  read,
    input  fpu_start,
    input  fpu_op
  );
endinterface

// File: rtl/fp_op_dispatch.sv
// fp_op_dispatch: pops opcodes from the FIFO, decodes
// them and issues one at a time to the FP datapath.
module fp_op_dispatch #(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  fp_op_dispatch_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             illegal_err,
  output logic             timeout_err,
  input  logic             err_clear
);
  localparam int LW = $clog2(RD_LAT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_ISSUE,
    S_BUSY,
    S_RETIRE
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             to_q, to_d;
  logic             read_q, read_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             ill_set, to_set;

  // Next state, counters and registered strobes
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    tmr_d   = tmr_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    ill_set = 1'b0;
    to_set  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.fifo_empty) state_d = S_POP;
      end
      S_POP: begin
        lat_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lat_q == LW'(RD_LAT - 1)) begin
          if (bus.opcode_in == 3'd0) begin
            state_d = S_RETIRE;
          end else if (bus.opcode_in >= 3'd6) begin
            ill_set = 1'b1;
            state_d = S_RETIRE;
          end else begin
            op_d    = bus.opcode_in;
            state_d = S_ISSUE;
          end
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_ISSUE: begin
        tmr_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (bus.fpu_done) begin
          state_d = S_RETIRE;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          to_set  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_RETIRE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // a new error on the clearing edge still sticks
    ill_d   = ill_set | (ill_q & ~err_clear);
    to_d    = to_set | (to_q & ~err_clear);
    read_d  = (state_d == S_POP);
    start_d = (state_d == S_ISSUE);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
      tmr_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      read_q  <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      tmr_q   <= tmr_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      read_q  <= read_d;
      start_q <= start_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.read      = read_q;
  assign bus.fpu_start = start_q;
  assign bus.fpu_op    = op_q;
  assign busy          = busy_q;
  assign op_count      = cnt_q;
  assign illegal_err   = ill_q;
  assign timeout_err   = to_q;
endmodule

// File: tb/tb_fp_op_dispatch.sv
// tb_fp_op_dispatch: FIFO and FPU models drive the DUT;
// a monitor scores each finished op against a queue.
module tb_fp_op_dispatch;
  localparam int RD_LAT  = 1;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;

  typedef struct {
    int op;
    int lat;
    bit spur;
  } rec_t;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             err_clear = 1'b0;
  logic             busy, illegal_err, timeout_err;
  logic [CNT_W-1:0] op_count;

  fp_op_dispatch_if bus();

  fp_op_dispatch #(
    .RD_LAT (RD_LAT),
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .bus        (bus),
    .busy       (busy),
    .op_count   (op_count),
    .illegal_err(illegal_err),
    .timeout_err(timeout_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail = 0;
  int   fifo_q[$];
  rec_t lat_q[$];
  rec_t exp_q[$];
  int   exp_cnt = 0;
  bit   exp_ill = 1'b0;
  bit   exp_to = 1'b0;
  int   last_op = 0;
  int   cyc = 0;

  task automatic check(string name, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // FIFO model: garbage on the pop edge, data RD_LAT later
  int         pend_cnt = 0;
  logic [2:0] pend_val = '0;
  always @(negedge clk) begin
    if (!n_rst) begin
      pend_cnt = 0;
    end else begin
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) bus.opcode_in = pend_val;
      end
      if (bus.read) begin
        if (fifo_q.size() == 0) begin
          check("pop_empty", 1, 0);
          pend_val = 3'd0;
        end else begin
          pend_val = 3'(fifo_q.pop_front());
        end
        pend_cnt = RD_LAT;
        bus.opcode_in = 3'($urandom);
      end
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  // FPU model: done pulse lat cycles after start
  int   done_cnt = 0;
  rec_t fr;
  always @(negedge clk) begin
    if (!n_rst) begin
      done_cnt = 0;
      bus.fpu_done = 1'b0;
    end else begin
      bus.fpu_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.fpu_done = 1'b1;
      end
      if (bus.fpu_start) begin
        if (lat_q.size() == 0) begin
          check("start_unexpected", 1, 0);
        end else begin
          fr = lat_q.pop_front();
          done_cnt = fr.lat;
          if (fr.spur) bus.fpu_done = 1'b1;
        end
      end
    end
  end

  // Monitor: scores every op when busy drops
  int   rd_n = 0;
  int   st_n = 0;
  int   st_op = 0;
  int   t_rd = 0;
  bit   pbusy = 1'b0;
  rec_t mr;
  int   e_lat;
  bit   issued;
  always @(negedge clk) begin
    cyc++;
    if (!n_rst) begin
      rd_n = 0;
      st_n = 0;
      pbusy = 1'b0;
    end else begin
      if (err_clear) begin
        exp_ill = 1'b0;
        exp_to = 1'b0;
      end
      if (bus.read) begin
        rd_n++;
        t_rd = cyc;
      end
      if (bus.fpu_start) begin
        st_n++;
        st_op = int'(bus.fpu_op);
      end
      if (pbusy && !busy) begin
        if (exp_q.size() == 0) begin
          check("op_unexpected", 1, 0);
        end else begin
          mr = exp_q.pop_front();
          issued = (mr.op >= 1 && mr.op <= 5);
          if (!issued) e_lat = RD_LAT + 2;
          else if (mr.lat == 0) e_lat = RD_LAT + TIMEOUT + 2;
          else e_lat = RD_LAT + mr.lat + 3;
          if (issued) last_op = mr.op;
          if (!(issued && mr.lat == 0))
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
          if (mr.op >= 6) exp_ill = 1'b1;
          if (issued && mr.lat == 0) exp_to = 1'b1;
          check("reads", rd_n, 1);
          check("starts", st_n, issued ? 1 : 0);
          if (issued) check("start_op", st_op, mr.op);
          check("latency", cyc - t_rd, e_lat);
          check("op_count", int'(op_count), exp_cnt);
          check("illegal_err", int'(illegal_err), int'(exp_ill));
          check("timeout_err", int'(timeout_err), int'(exp_to));
          check("fpu_op_hold", int'(bus.fpu_op), last_op);
        end
        rd_n = 0;
        st_n = 0;
      end
      pbusy = busy;
    end
  end

  task automatic push_op(int op, int lat, bit spur);
    rec_t r;
    r.op = op;
    r.lat = lat;
    r.spur = spur;
    fifo_q.push_back(op);
    exp_q.push_back(r);
    if (op >= 1 && op <= 5) lat_q.push_back(r);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy)
               && n < 3000);
    if (n >= 3000) check("drain_timeout", 0, 1);
  endtask

  task automatic clear_pulse();
    #1 err_clear = 1'b1;
    @(negedge clk);
    #1 err_clear = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_read(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.read) seen = 1'b1;
    end
    if (!seen) check("read_wait", 0, 1);
  endtask

  bit seen;
  int cnt_snap;

  initial begin
    bus.fifo_empty = 1'b1;
    bus.opcode_in = 3'd0;
    bus.fpu_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_read", int'(bus.read), 0);
    check("rst_start", int'(bus.fpu_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_fpu_op", int'(bus.fpu_op), 0);
    check("rst_count", int'(op_count), 0);
    check("rst_errs", int'({illegal_err, timeout_err}), 0);
    #1 n_rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet",
            int'({bus.read, bus.fpu_start, busy}), 0);
    end
    check("idle_count", int'(op_count), 0);

    push_op(1, 3, 1'b0);
    wait_idle();
    check("add_count", int'(op_count), 1);

    push_op(3, 2, 1'b0);
    push_op(0, 0, 1'b0);
    push_op(5, 1, 1'b1);
    wait_idle();
    check("b2b_count", int'(op_count), 4);

    push_op(7, 0, 1'b0);
    wait_idle();
    check("illegal_set", int'(illegal_err), 1);
    clear_pulse();
    check("illegal_clr", int'(illegal_err), 0);

    push_op(6, 0, 1'b0);
    wait_read(seen);
    #1 err_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 err_clear = 1'b0;
    wait_idle();
    check("set_wins", int'(illegal_err), 1);
    clear_pulse();

    push_op(2, 0, 1'b0);
    wait_idle();
    check("timeout_set", int'(timeout_err), 1);
    check("timeout_count", int'(op_count), 6);
    #1 bus.fpu_done = 1'b1;
    repeat (3) @(negedge clk);
    check("late_done_cnt", int'(op_count), 6);
    check("late_done_busy", int'(busy), 0);
    clear_pulse();
    check("timeout_clr", int'(timeout_err), 0);

    for (int b = 0; b < 30; b++) begin
      for (int k = 0; k < int'($urandom_range(1, 4)); k++)
        push_op(int'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0) ? 0
                  : int'($urandom_range(1, 5)),
                bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) begin
        wait_idle();
        if ($urandom_range(0, 1) == 0) clear_pulse();
      end else begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    wait_idle();

    push_op(4, 5, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.fpu_start) seen = 1'b1;
    end
    check("start_wait", int'(seen), 1);
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_strobes",
          int'({bus.read, bus.fpu_start}), 0);
    check("mid_rst_fpu_op", int'(bus.fpu_op), 0);
    check("mid_rst_count", int'(op_count), 0);
    check("mid_rst_errs",
          int'({illegal_err, timeout_err}), 0);
    fifo_q.delete();
    lat_q.delete();
    exp_q.delete();
    exp_cnt = 0;
    exp_ill = 1'b0;
    exp_to = 1'b0;
    last_op = 0;
    repeat (2) @(negedge clk);
    push_op(1, 2, 1'b0);
    @(negedge clk);
    #1 n_rst = 1'b1;
    check("rel_read_lo", int'(bus.read), 0);
    @(negedge clk);
    check("rel_read_hi", int'(bus.read), 1);
    wait_idle();
    check("rel_count", int'(op_count), 1);
    cnt_snap = int'(op_count);
    repeat (2) @(negedge clk);
    check("final_stable", int'(op_count), cnt_snap);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
